// File: rtl/ngs_mailbox_fifo_if.sv
// rtl/ngs_mailbox_fifo_if.sv - Z80 port bus and ZX-side FIFO handshake bundle
interface ngs_mailbox_fifo_if;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd_hit;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        zx_wr_stb;
    logic [7:0]  zx_wr_data;
    logic        zx_rd_stb;
    logic [7:0]  zx_rd_data;
    logic        zx_rx_full;
    logic        zx_tx_avail;
    logic        irq;

    modport master (
        output a, din, iorq_n, rd_n, wr_n, zx_wr_stb, zx_wr_data, zx_rd_stb,
        input  dout, rd_hit, zx_rd_data, zx_rx_full, zx_tx_avail, irq
    );

    modport slave (
        input  a, din, iorq_n, rd_n, wr_n, zx_wr_stb, zx_wr_data, zx_rd_stb,
        output dout, rd_hit, zx_rd_data, zx_rx_full, zx_tx_avail, irq
    );
endinterface

// File: rtl/ngs_mailbox_fifo.sv
// rtl/ngs_mailbox_fifo.sv - ZX<->NGS byte mailbox FIFOs with 4-port Z80 window (optional NGS_MAILBOX_IRQ_EN)
module ngs_mailbox_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [5:0]  BASE       = 6'h20,
    parameter logic [7:0]  EMPTY_VAL  = 8'hFF
) (
    input  logic               cpu_clock,
    input  logic               rst_n,
    ngs_mailbox_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LW-1:0]         lvl_t;

    localparam lvl_t FULL_LVL = lvl_t'(DEPTH);

    // Z80 strobe detection
    logic wr_act, rd_act;
    logic wr_act_q, rd_act_q, port_wr_q, port_rd_q;

    assign wr_act = ~(bus.iorq_n | bus.wr_n);
    assign rd_act = ~(bus.iorq_n | bus.rd_n);

    // Edge-detect the active-low I/O cycles into registered one-cycle pulses
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_act_q  <= 1'b0;
            rd_act_q  <= 1'b0;
            port_wr_q <= 1'b0;
            port_rd_q <= 1'b0;
        end else begin
            wr_act_q  <= wr_act;
            rd_act_q  <= rd_act;
            port_wr_q <= wr_act & ~wr_act_q;
            port_rd_q <= rd_act & ~rd_act_q;
        end
    end

    // Window decode; the FPGA port space only uses the low address byte
    logic       win_hit;
    logic [1:0] sel;
    logic       unused_addr;
    assign win_hit     = (bus.a[7:6] == 2'b00) && (bus.a[5:2] == BASE[5:2]);
    assign sel         = bus.a[1:0];
    assign unused_addr = ^bus.a[15:8];
    assign bus.rd_hit  = win_hit & rd_act;

    logic rx_pop, tx_push, reg1_wr, rx_clr, tx_clr, sticky_clr;
    assign rx_pop     = port_rd_q & win_hit & (sel == 2'd0);
    assign tx_push    = port_wr_q & win_hit & (sel == 2'd0);
    assign reg1_wr    = port_wr_q & win_hit & (sel == 2'd1);
    assign rx_clr     = reg1_wr & bus.din[0];
    assign tx_clr     = reg1_wr & bus.din[1];
    assign sticky_clr = reg1_wr & bus.din[2];

    // FIFO state
    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];
    ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    lvl_t rx_lvl_q, rx_lvl_d, tx_lvl_q, tx_lvl_d;
    logic rx_ovr_q, rx_ovr_d, tx_ovr_q, tx_ovr_d, rx_unf_q, rx_unf_d;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_pop_ok, rx_push_ok, tx_pop_ok, tx_push_ok;
    assign rx_empty   = (rx_lvl_q == '0);
    assign rx_full    = (rx_lvl_q == FULL_LVL);
    assign tx_empty   = (tx_lvl_q == '0);
    assign tx_full    = (tx_lvl_q == FULL_LVL);
    // A pop frees the slot in the same cycle, so a full FIFO can still accept a push
    assign rx_pop_ok  = rx_pop & ~rx_empty;
    assign rx_push_ok = bus.zx_wr_stb & (~rx_full | rx_pop_ok);
    assign tx_pop_ok  = bus.zx_rd_stb & ~tx_empty;
    assign tx_push_ok = tx_push & (~tx_full | tx_pop_ok);

    // Next-state for pointers, levels and sticky flags; clear beats push/pop
    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_lvl_d  = rx_lvl_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_lvl_d  = tx_lvl_q;
        rx_ovr_d  = rx_ovr_q & ~sticky_clr;
        tx_ovr_d  = tx_ovr_q & ~sticky_clr;
        rx_unf_d  = rx_unf_q & ~sticky_clr;
        if (rx_clr) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_lvl_d  = '0;
        end else begin
            if (rx_push_ok) rx_wptr_d = rx_wptr_q + 1'b1;
            if (rx_pop_ok)  rx_rptr_d = rx_rptr_q + 1'b1;
            rx_lvl_d = rx_lvl_q + lvl_t'(rx_push_ok) - lvl_t'(rx_pop_ok);
            if (bus.zx_wr_stb & ~rx_push_ok) rx_ovr_d = 1'b1;
            if (rx_pop & rx_empty)           rx_unf_d = 1'b1;
        end
        if (tx_clr) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_lvl_d  = '0;
        end else begin
            if (tx_push_ok) tx_wptr_d = tx_wptr_q + 1'b1;
            if (tx_pop_ok)  tx_rptr_d = tx_rptr_q + 1'b1;
            tx_lvl_d = tx_lvl_q + lvl_t'(tx_push_ok) - lvl_t'(tx_pop_ok);
            if (tx_push & ~tx_push_ok) tx_ovr_d = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_lvl_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_lvl_q  <= '0;
            rx_ovr_q  <= 1'b0;
            tx_ovr_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_lvl_q  <= rx_lvl_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_lvl_q  <= tx_lvl_d;
            rx_ovr_q  <= rx_ovr_d;
            tx_ovr_q  <= tx_ovr_d;
            rx_unf_q  <= rx_unf_d;
        end
    end

    // Byte storage; contents are don't-care until the level covers them
    always_ff @(posedge cpu_clock) begin
        if (!rx_clr && rx_push_ok) rx_mem[rx_wptr_q] <= bus.zx_wr_data;
        if (!tx_clr && tx_push_ok) tx_mem[tx_wptr_q] <= bus.din;
    end

    // RX level threshold interrupt
    logic irq_w;
`ifdef NGS_MAILBOX_IRQ_EN
    logic [7:0] thr_q;

    // Threshold register, written through port +3
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= 8'd1;
        end else if (port_wr_q && win_hit && sel == 2'd3) begin
            thr_q <= bus.din;
        end
    end

    assign irq_w = (thr_q != 8'd0) && (8'(rx_lvl_q) >= thr_q);
`else
    assign irq_w = 1'b0;
`endif

    logic [7:0] status;
    assign status = {rx_empty, rx_full, tx_empty, tx_full, rx_ovr_q, tx_ovr_q, rx_unf_q, irq_w};

    assign bus.irq         = irq_w;
    assign bus.zx_rx_full  = rx_full;
    assign bus.zx_tx_avail = ~tx_empty;
    assign bus.zx_rd_data  = tx_empty ? EMPTY_VAL : tx_mem[tx_rptr_q];

    // Zero-latency read mux for the port window
    always_comb begin
        bus.dout = 8'h00;
        if (win_hit) begin
            case (sel)
                2'd0:    bus.dout = rx_empty ? EMPTY_VAL : rx_mem[rx_rptr_q];
                2'd1:    bus.dout = status;
                2'd2:    bus.dout = 8'(rx_lvl_q);
                default: bus.dout = 8'(tx_lvl_q);
            endcase
        end
    end
endmodule
